// File: rtl/bip_debug_unit.sv
// UART-side run controller for BIP1: waits for a start byte, runs the CPU until
// HALT or a cycle limit, then streams a 7-byte status/ACC/PC/cycle report.
module bip_debug_unit #(
  parameter int                DBIT       = 8,
  parameter int                NB_PC      = 11,
  parameter int                NB_DATA    = 16,
  parameter int                NB_CYC     = 16,
  parameter logic [NB_CYC-1:0] MAX_CYCLES = 16'hFFFF,
  parameter logic [DBIT-1:0]   CMD_START  = 8'h53
) (
  input  logic               i_clk,
  input  logic               i_reset,
  input  logic               i_rx_done_tick,
  input  logic [DBIT-1:0]    i_rx_data,
  input  logic               i_tx_done_tick,
  input  logic               i_halt,
  input  logic [NB_PC-1:0]   i_pc,
  input  logic [NB_DATA-1:0] i_acc,
  output logic               o_cpu_reset,
  output logic               o_cpu_enable,
  output logic               o_tx_start,
  output logic [DBIT-1:0]    o_tx_data,
  output logic               o_busy
);

  typedef enum logic [2:0] {
    S_IDLE, S_CLEAR, S_RUN, S_SEND, S_WAIT_TX
  } state_t;

  state_t            state, state_n;
  logic [NB_CYC-1:0] cyc, cyc_n;
  logic [7:0]        status, status_n;
  logic [15:0]       acc_q, acc_n, pc_q, pc_n;
  logic [2:0]        idx, idx_n;
  logic [15:0]       cyc16;
  logic [7:0]        byte_n;

  // The counter register doubles as the cycle snapshot: it freezes once RUN exits.
  always_comb begin
    state_n  = state;
    cyc_n    = cyc;
    status_n = status;
    acc_n    = acc_q;
    pc_n     = pc_q;
    idx_n    = idx;
    case (state)
      S_IDLE:
        if (i_rx_done_tick && (i_rx_data == CMD_START)) state_n = S_CLEAR;
      S_CLEAR: begin
        cyc_n   = '0;
        state_n = S_RUN;
      end
      S_RUN: begin
        cyc_n = cyc + 1'b1;
        if (i_halt || (cyc_n == MAX_CYCLES)) begin
          status_n = i_halt ? 8'h00 : 8'h01;
          acc_n    = 16'(i_acc);
          pc_n     = 16'(i_pc);
          idx_n    = '0;
          state_n  = S_SEND;
        end
      end
      S_SEND:
        state_n = S_WAIT_TX;
      S_WAIT_TX:
        if (i_tx_done_tick) begin
          if (idx == 3'd6) begin
            state_n = S_IDLE;
          end else begin
            idx_n   = idx + 3'd1;
            state_n = S_SEND;
          end
        end
      default:
        state_n = S_IDLE;
    endcase
  end

  // Byte selected from next-state values so the registered data lines up with tx_start.
  always_comb begin
    cyc16 = 16'(cyc_n);
    case (idx_n)
      3'd0:    byte_n = status_n;
      3'd1:    byte_n = acc_n[15:8];
      3'd2:    byte_n = acc_n[7:0];
      3'd3:    byte_n = pc_n[15:8];
      3'd4:    byte_n = pc_n[7:0];
      3'd5:    byte_n = cyc16[15:8];
      default: byte_n = cyc16[7:0];
    endcase
  end

  always_ff @(posedge i_clk) begin
    if (!i_reset) begin
      state        <= S_IDLE;
      cyc          <= '0;
      status       <= '0;
      acc_q        <= '0;
      pc_q         <= '0;
      idx          <= '0;
      o_cpu_reset  <= 1'b1;
      o_cpu_enable <= 1'b0;
      o_tx_start   <= 1'b0;
      o_tx_data    <= '0;
      o_busy       <= 1'b0;
    end else begin
      state        <= state_n;
      cyc          <= cyc_n;
      status       <= status_n;
      acc_q        <= acc_n;
      pc_q         <= pc_n;
      idx          <= idx_n;
      o_cpu_reset  <= (state_n == S_IDLE) || (state_n == S_CLEAR);
      o_cpu_enable <= (state_n == S_RUN);
      o_tx_start   <= (state_n == S_SEND);
      o_busy       <= (state_n != S_IDLE);
      if (state_n == S_SEND) o_tx_data <= DBIT'(byte_n);
    end
  end

endmodule
